led_display_ctrl: RTL and testbench
===================================

Name: led_display_ctrl

Overview:
- Multi-channel, parametrised LED display driver; successor to the single-register LED displayer.
- Holds CHANNELS words of WIDTH bits, each loaded by its own strobe.
- Drives one WIDTH-bit LED bank in one of four modes: direct, latched, blinking or auto-scroll.
- Sits between calculator datapath outputs and board LEDs; one clock domain.

Parameters:
- WIDTH, 8: bits per channel and LED bank width.
- CHANNELS, 4: number of stored channels, >=1.
- PRESCALE, 50_000_000: clk cycles per display tick (1 Hz at 50 MHz), >=2.
- SEL_W, max(1,$clog2(CHANNELS)): channel index width (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- load  in  CHANNELS  per-channel capture strobe.
- mode  in  2  00 DIRECT, 01 LATCH, 10 BLINK, 11 SCROLL.
- sel  in  SEL_W  displayed channel for DIRECT/LATCH/BLINK.
- led_out  out  WIDTH  registered LED drive.
- cur_chan  out  SEL_W  index of channel currently shown, registered with led_out.
- tick  out  1  one-cycle pulse every PRESCALE cycles.

Behaviour:
- Reset (async assert, sync-safe release): chan_reg[*]=0, led_out=0, cur_chan=0, prescaler=0, tick=0, blink_on=1, scroll_idx=0.
- Channel capture: load[i]=1 at edge -> chan_reg[i] <= data_in slice i. Independent per channel; capture runs in every mode. Multiple simultaneous loads all capture.
- Prescaler:
  - Free-running 0..PRESCALE-1, wraps to 0.
  - tick=1 in the cycle after count==PRESCALE-1 (registered), i.e. first tick PRESCALE cycles after reset release.
- Channel index: sel>=CHANNELS (non-power-of-2 CHANNELS) maps to 0. Same rule for scroll_idx.
- DIRECT: led_out <= data_in slice sel. One-cycle latency; load ignored for display.
- LATCH: led_out <= chan_reg[sel]. load at edge n is visible on led_out after edge n+1 (2-cycle latency). Loading the displayed channel shows the old value for one more cycle.
- BLINK:
  - led_out <= blink_on ? chan_reg[sel] : 0.
  - blink_on toggles on each tick while in BLINK.
  - Outside BLINK, blink_on is forced to 1, so entering BLINK always starts lit.
- SCROLL:
  - led_out <= chan_reg[scroll_idx].
  - scroll_idx increments on tick, wrapping CHANNELS-1 -> 0.
  - Outside SCROLL, scroll_idx <= sel, so scrolling starts at the selected channel.
  - CHANNELS=1: scroll_idx stays 0.
- cur_chan: sel (mapped) in DIRECT/LATCH/BLINK, scroll_idx in SCROLL. Updates on the same edge as led_out.
- Mode change takes effect on the next edge. No pipeline flush needed; prescaler is not reset by a mode change.
- Reset mid-operation: all state returns to reset values immediately. Prescaler restarts, so the next tick is PRESCALE cycles after release.

Decomposition:
- Package led_disp_pkg:
  - Mode constants MODE_DIRECT=2'b00, MODE_LATCH=2'b01, MODE_BLINK=2'b10, MODE_SCROLL=2'b11.
  - Helper function for the SEL_W computation.
- Sub-module led_tick_gen (parameter PRESCALE; ports clk, rst, tick): prescaler counter and registered tick.
- Channel registers, mode mux and blink/scroll state stay in led_display_ctrl.

Test Plan (WIDTH=8, CHANNELS=4, PRESCALE=4):
- Reset: assert rst mid-run with led_out=8'hA5 -> led_out=0, cur_chan=0 immediately. First tick 4 cycles after release.
- DIRECT: mode=00, sel=2, data_in slice2=8'h3C -> led_out=8'h3C one edge later. load stays 0, and chan_reg stays 0 in LATCH.
- LATCH: load[1] with 8'h81, mode=01, sel=1 -> led_out=8'h81 after 2 edges. Slice1 then changes to 8'hFF without load -> led_out stays 8'h81.
- BLINK: chan_reg[0]=8'h0F, mode=10, sel=0 -> led_out 8'h0F, then 8'h00 after first tick, then 8'h0F after next. Toggles every 4 cycles.
- SCROLL: chan_reg = {8'h44,8'h33,8'h22,8'h11}, sel=3, mode=11 -> cur_chan/led_out 3/8'h44, then 0/8'h11, 1/8'h22 on successive ticks (wrap verified).
- Simultaneous: load[2] with 8'h5A in the same cycle as a LATCH display of channel 2 -> old value for one cycle, then 8'h5A. load=4'b1111 loads all four channels in one cycle.

Source files
------------

// File: rtl/led_disp_pkg.sv
// Shared mode encoding and the channel-index width helper for the LED display driver.
package led_disp_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_LATCH  = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_SCROLL = 2'b11
  } mode_e;

  // A single channel still needs a 1-bit select port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler; tick pulses for one cycle every PRESCALE clocks.
module led_tick_gen #(
  parameter int PRESCALE = 50_000_000
)(
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // tick is registered, so it appears the cycle after the count hits LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_display_ctrl.sv
// Multi-channel LED bank driver: per-channel capture registers feeding a
// direct / latched / blinking / auto-scroll output mux.
module led_display_ctrl
  import led_disp_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  parameter  int PRESCALE = 50_000_000,
  localparam int SEL_W    = sel_width(CHANNELS)
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       load,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          led_out,
  output logic [SEL_W-1:0]          cur_chan,
  output logic                      tick
);
  localparam logic [SEL_W:0]   NUM_CH  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [CHANNELS-1:0][WIDTH-1:0] din;
  logic [CHANNELS-1:0][WIDTH-1:0] chan_reg;
  logic [SEL_W-1:0]               sel_m;
  logic [SEL_W-1:0]               scroll_idx;
  logic                           blink_on;
  logic [WIDTH-1:0]               nxt_led;
  logic [SEL_W-1:0]               nxt_chan;

  assign din = data_in;

  // Out-of-range selects (non-power-of-2 CHANNELS) fall back to channel 0.
  assign sel_m = ({1'b0, sel} < NUM_CH) ? sel : '0;

  led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chan_reg <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        if (load[i]) chan_reg[i] <= din[i];
    end
  end

  // Blink phase and scroll position are pinned while their mode is inactive
  // so each mode always starts lit / at the selected channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_on   <= 1'b1;
      scroll_idx <= '0;
    end else begin
      if (mode_e'(mode) != MODE_BLINK) blink_on <= 1'b1;
      else if (tick)                   blink_on <= ~blink_on;

      if (mode_e'(mode) != MODE_SCROLL) scroll_idx <= sel_m;
      else if (tick)                    scroll_idx <= (scroll_idx == LAST_CH) ? '0 : scroll_idx + 1'b1;
    end
  end

  always_comb begin
    nxt_led  = chan_reg[sel_m];
    nxt_chan = sel_m;
    case (mode_e'(mode))
      MODE_DIRECT: nxt_led = din[sel_m];
      MODE_LATCH:  nxt_led = chan_reg[sel_m];
      MODE_BLINK:  nxt_led = blink_on ? chan_reg[sel_m] : '0;
      MODE_SCROLL: begin
        nxt_led  = chan_reg[scroll_idx];
        nxt_chan = scroll_idx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out  <= '0;
      cur_chan <= '0;
    end else begin
      led_out  <= nxt_led;
      cur_chan <= nxt_chan;
    end
  end

endmodule

// File: tb/tb_led_display_ctrl.sv
// Scoreboard bench: a cycle-level reference model predicts every output edge,
// a monitor compares; directed checks follow the test plan, then random traffic.
module tb_led_display_ctrl;
  import led_disp_pkg::*;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int P  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH*W-1:0] data_in = '0;
  logic [CH-1:0]   load = '0;
  logic [1:0]      mode = MODE_DIRECT;
  logic [SW-1:0]   sel = '0;
  logic [W-1:0]    led_out;
  logic [SW-1:0]   cur_chan;
  logic            tick;

  led_display_ctrl #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .load     (load),
    .mode     (mode),
    .sel      (sel),
    .led_out  (led_out),
    .cur_chan (cur_chan),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [W-1:0]  led;
    logic [SW-1:0] ch;
    logic          tk;
  } exp_t;

  exp_t q[$];

  // Reference state: stored words, blink phase, scroll position, edges since reset.
  logic [W-1:0] m_chan [CH];
  bit           m_blink;
  int           m_scroll;
  int           m_k;

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) m_chan[i] = '0;
    m_blink  = 1'b1;
    m_scroll = 0;
    m_k      = 0;
  endfunction

  // Predict the outputs produced by the coming clock edge, then advance the model.
  function automatic void model_edge();
    exp_t e;
    int   s;
    bit   tk_now;
    s      = (int'(sel) < CH) ? int'(sel) : 0;
    tk_now = (m_k > 0) && (m_k % P == 0);
    e.ch   = SW'(s);
    case (mode)
      MODE_DIRECT: e.led = data_in[s*W +: W];
      MODE_LATCH:  e.led = m_chan[s];
      MODE_BLINK:  e.led = m_blink ? m_chan[s] : '0;
      default: begin
        e.led = m_chan[m_scroll];
        e.ch  = SW'(m_scroll);
      end
    endcase
    for (int i = 0; i < CH; i++)
      if (load[i]) m_chan[i] = data_in[i*W +: W];
    if (mode != MODE_BLINK) m_blink = 1'b1;
    else if (tk_now)        m_blink = ~m_blink;
    if (mode != MODE_SCROLL) m_scroll = s;
    else if (tk_now)         m_scroll = (m_scroll + 1) % CH;
    m_k  = m_k + 1;
    e.tk = (m_k % P == 0);
    q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every out-of-reset edge must match the oldest prediction.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (!rst) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got an edge with no prediction, expected one queued");
      end else begin
        e = q.pop_front();
        chk("sb_led_out", 32'(led_out), 32'(e.led));
        chk("sb_cur_chan", 32'(cur_chan), 32'(e.ch));
        chk("sb_tick", 32'(tick), 32'(e.tk));
      end
    end
  end

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_led_out", 32'(led_out), 32'h0);
    chk("rst_cur_chan", 32'(cur_chan), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance until tick is high in the current cycle (bounded).
  task automatic sync_tick();
    for (int i = 0; i < 2*P && !tick; i++) step();
    chk("tick_seen", 32'(tick), 32'h1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_led_out", 32'(led_out), 32'h0);
    chk("init_cur_chan", 32'(cur_chan), 32'h0);
    rst = 1'b0;

    // DIRECT shows the live slice one edge later; nothing is captured.
    mode = MODE_DIRECT; sel = 2'd2; data_in[2*W +: W] = 8'h3C;
    step();
    chk("direct_led", 32'(led_out), 32'h3C);
    chk("direct_chan", 32'(cur_chan), 32'h2);
    mode = MODE_LATCH;
    step(); step();
    chk("latch_no_load", 32'(led_out), 32'h0);

    // Reset mid-run from a lit display; first tick P edges after release.
    mode = MODE_DIRECT; sel = 2'd1; data_in[1*W +: W] = 8'hA5;
    step();
    chk("pre_rst_led", 32'(led_out), 32'hA5);
    do_reset();
    for (int i = 0; i < P-1; i++) step();
    chk("tick_early", 32'(tick), 32'h0);
    step();
    chk("tick_first", 32'(tick), 32'h1);

    // LATCH: two-edge latency, then unloaded input changes are ignored.
    mode = MODE_LATCH; sel = 2'd1; data_in[1*W +: W] = 8'h81; load = 4'b0010;
    step();
    load = '0;
    chk("latch_old", 32'(led_out), 32'h0);
    step();
    chk("latch_new", 32'(led_out), 32'h81);
    data_in[1*W +: W] = 8'hFF;
    step(); step();
    chk("latch_hold", 32'(led_out), 32'h81);

    // BLINK: starts lit, goes dark after a tick, relights four cycles later.
    mode = MODE_DIRECT; data_in[0 +: W] = 8'h0F; load = 4'b0001;
    step();
    load = '0;
    sync_tick();
    step();
    mode = MODE_BLINK; sel = 2'd0;
    step();
    chk("blink_lit", 32'(led_out), 32'h0F);
    repeat (3) step();
    step();
    chk("blink_dark", 32'(led_out), 32'h00);
    repeat (4) step();
    chk("blink_relit", 32'(led_out), 32'h0F);

    // SCROLL from channel 3, wrapping to 0 then 1; all four loaded at once.
    mode = MODE_DIRECT; sel = 2'd3;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11}; load = 4'b1111;
    step();
    load = '0;
    sync_tick();
    mode = MODE_SCROLL;
    step();
    chk("scroll_start_led", 32'(led_out), 32'h44);
    chk("scroll_start_chan", 32'(cur_chan), 32'h3);
    step();
    chk("scroll_wrap_led", 32'(led_out), 32'h11);
    chk("scroll_wrap_chan", 32'(cur_chan), 32'h0);
    repeat (4) step();
    chk("scroll_next_led", 32'(led_out), 32'h22);
    chk("scroll_next_chan", 32'(cur_chan), 32'h1);

    // Load of the displayed channel: old word for one more edge.
    mode = MODE_LATCH; sel = 2'd2;
    step(); step();
    chk("sim_before", 32'(led_out), 32'h33);
    data_in[2*W +: W] = 8'h5A; load = 4'b0100;
    step();
    load = '0;
    chk("sim_old", 32'(led_out), 32'h33);
    step();
    chk("sim_new", 32'(led_out), 32'h5A);

    // Random traffic, one mid-run reset, all checked by the scoreboard.
    for (int n = 0; n < 400; n++) begin
      data_in = {$urandom, $urandom};
      for (int i = 0; i < CH; i++) load[i] = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) mode = 2'($urandom);
      if ($urandom_range(5) == 0) sel  = SW'($urandom);
      if (n == 200) do_reset();
      step();
    end

    load = '0;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: got %0d unchecked predictions, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
